alarm_ringer: RTL
=================

// Module: alarm_ringer
// PURPOSE
//  Responder side of the alarm-compare handshake. Consumes the registered Trigger from the
//  alarm comparator and drives the buzzer. Handles stop/snooze buttons and ring timeout.
//  Returns feedback, which blocks re-triggering until the matching minute has passed.
//  Sits between the alarm comparator and the buzzer/LED output stage.
// PARAMETERS
//  RING_S      60   seconds of ringing before auto-stop
//  SNOOZE_S    300  seconds of silence per snooze
//  HOLD_S      60   seconds feedback stays high after stop (covers the matching minute)
//  MAX_SNOOZE  3    snoozes allowed per alarm event; later snooze presses are ignored
//  CNT_W       9    second-counter width; must hold max(RING_S,SNOOZE_S,HOLD_S)
// PORTS
//  clk        in   1  system clock
//  reset_     in   1  asynchronous active-low reset
//  tick       in   1  1 Hz enable, one clk wide
//  Trigger    in   1  alarm match from comparator (level)
//  btn_stop   in   1  stop button; debounced and synchronous to clk
//  btn_snooze in   1  snooze button; debounced and synchronous to clk
//  Buzzer     out  1  buzzer drive
//  feedback   out  1  to comparator; 1 = alarm being serviced, suppress Trigger
//  Ringing    out  1  1 while in RING (LED indicator)
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, Buzzer=0, feedback=0, Ringing=0,
//    cnt=0, snz_cnt=0, button edge registers=0.
//  - Buttons act on the rising edge only (prev-level register). Holding a button is one press.
//  - FSM: IDLE=2'b00, RING=2'b01, SNOOZE=2'b10, HOLD=2'b11.
//  - IDLE: Buzzer=0, feedback=0. Trigger=1 -> RING on the next clk.
//    On entry: cnt=0, snz_cnt=0, Buzzer=1. Buttons are ignored in IDLE.
//  - RING: feedback=1, Ringing=1. Buzzer toggles on each tick (1 s on / 1 s off).
//    cnt increments on tick.
//  - SNOOZE: Buzzer=0, feedback=1, Ringing=0. cnt increments on tick.
//    When cnt==SNOOZE_S-1 at a tick -> RING with cnt=0 and Buzzer=1.
//  - HOLD: Buzzer=0, feedback=1. cnt increments on tick.
//    When cnt==HOLD_S-1 at a tick -> IDLE with feedback=0 on the next clk.
//  - RING exits, in priority order when events coincide in the same clk:
//    1. stop edge -> HOLD.
//    2. snooze edge with snz_cnt<MAX_SNOOZE -> SNOOZE; snz_cnt++.
//    3. cnt==RING_S-1 at a tick -> HOLD.
//    On every exit cnt=0 and Buzzer=0.
//  - SNOOZE exits: a stop edge -> HOLD, cnt=0. A stop edge beats a same-cycle snooze expiry.
//  - Trigger is ignored outside IDLE. The comparator drops Trigger once it sees feedback=1.
//    feedback must stay high through HOLD so the same minute cannot re-fire.
//  - Latency: Trigger -> Buzzer/feedback = 1 clk. Button edge -> state change = 1 clk
//    after the edge register.
//  - Counter does not wrap: compare-equal is the only exit, and cnt resets on every
//    state entry.
//  - Reset mid-ring: Buzzer, feedback and Ringing drop asynchronously.
// CONFIGURATION
//  ALARM_SNOOZE_EN defined:
//    snooze path present as above.
//  ALARM_SNOOZE_EN undefined:
//    btn_snooze ignored, SNOOZE state unreachable, snz_cnt removed.
//    RING exits only on stop or timeout; port list unchanged.
// TESTING (RING_S=4, SNOOZE_S=3, HOLD_S=2, MAX_SNOOZE=1; tick every 10 clk)
//  1. Trigger=1 for 1 clk from IDLE -> next clk Buzzer=1, feedback=1, Ringing=1.
//     No presses -> Buzzer 1,0,1,0 per tick. After 4 ticks: HOLD. After 2 more ticks:
//     IDLE, feedback=0.
//  2. Ring, press stop after 1 tick -> next clk Buzzer=0, Ringing=0, feedback stays 1
//     for 2 ticks, then 0.
//  3. Ring, snooze -> Buzzer=0 for 3 ticks, then RING with Buzzer=1.
//     Second snooze press ignored (MAX_SNOOZE=1); stop -> HOLD.
//  4. Stop and snooze edges in the same clk while ringing -> HOLD (stop wins).
//     Held stop button: only one transition occurs.
//  5. Assert reset_=0 mid-RING, asynchronously -> Buzzer=0, feedback=0 immediately.
//     After release, state is IDLE.
//  6. Build without ALARM_SNOOZE_EN, press snooze during RING -> no effect;
//     timeout after 4 ticks.

Source files
------------

// File: rtl/alarm_ringer.sv
// Alarm responder: drives the buzzer after a comparator match and holds feedback until the minute passes.
// Optional snooze path compiled in with ALARM_SNOOZE_EN.
module alarm_ringer #(
    parameter int unsigned RING_S     = 60,
    parameter int unsigned SNOOZE_S   = 300,
    parameter int unsigned HOLD_S     = 60,
    parameter int unsigned MAX_SNOOZE = 3,
    parameter int unsigned CNT_W      = 9
) (
    input  logic clk,
    input  logic reset_,
    input  logic tick,
    input  logic Trigger,
    input  logic btn_stop,
    input  logic btn_snooze,
    output logic Buzzer,
    output logic feedback,
    output logic Ringing
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RING   = 2'b01,
        SNOOZE = 2'b10,
        HOLD   = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               buzzer_q, buzzer_d;
    logic               feedback_q, feedback_d;
    logic               ringing_q, ringing_d;
    logic               stop_prev_q;
    logic               stop_edge_c;
    logic [CNT_W-1:0]   cnt_inc_c;

`ifdef ALARM_SNOOZE_EN
    localparam int unsigned SNZ_W = (MAX_SNOOZE == 0) ? 1 : $clog2(MAX_SNOOZE + 1);

    logic [SNZ_W-1:0]   snz_cnt_q, snz_cnt_d;
    logic               snz_prev_q;
    logic               snz_edge_c;
    logic               snz_ok_c;

    assign snz_edge_c = btn_snooze & ~snz_prev_q;
    assign snz_ok_c   = 32'(snz_cnt_q) < MAX_SNOOZE;
`else
    // Snooze path compiled out; keep the port and parameters visibly consumed.
    localparam int unsigned unused_snooze_cfg = SNOOZE_S + MAX_SNOOZE;
    logic unused_snooze_c;
    assign unused_snooze_c = btn_snooze;
`endif

    assign stop_edge_c = btn_stop & ~stop_prev_q;
    assign cnt_inc_c   = cnt_q + CNT_W'(1);

    assign Buzzer   = buzzer_q;
    assign feedback = feedback_q;
    assign Ringing  = ringing_q;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            buzzer_q    <= 1'b0;
            feedback_q  <= 1'b0;
            ringing_q   <= 1'b0;
            stop_prev_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q   <= '0;
            snz_prev_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buzzer_q    <= buzzer_d;
            feedback_q  <= feedback_d;
            ringing_q   <= ringing_d;
            stop_prev_q <= btn_stop;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q   <= snz_cnt_d;
            snz_prev_q  <= btn_snooze;
`endif
        end
    end

    // Next-state and registered-output values; exits in RING follow stop > snooze > timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buzzer_d  = buzzer_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d = snz_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                buzzer_d = 1'b0;
                if (Trigger) begin
                    state_d   = RING;
                    cnt_d     = '0;
                    buzzer_d  = 1'b1;
`ifdef ALARM_SNOOZE_EN
                    snz_cnt_d = '0;
`endif
                end
            end
            RING: begin
                if (stop_edge_c) begin
                    state_d  = HOLD;
                    cnt_d    = '0;
                    buzzer_d = 1'b0;
                end
`ifdef ALARM_SNOOZE_EN
                else if (snz_edge_c && snz_ok_c) begin
                    state_d   = SNOOZE;
                    cnt_d     = '0;
                    buzzer_d  = 1'b0;
                    snz_cnt_d = snz_cnt_q + SNZ_W'(1);
                end
`endif
                else if (tick) begin
                    if (cnt_q == CNT_W'(RING_S - 1)) begin
                        state_d  = HOLD;
                        cnt_d    = '0;
                        buzzer_d = 1'b0;
                    end else begin
                        cnt_d    = cnt_inc_c;
                        buzzer_d = ~buzzer_q;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                buzzer_d = 1'b0;
                if (stop_edge_c) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_W'(SNOOZE_S - 1)) begin
                        state_d  = RING;
                        cnt_d    = '0;
                        buzzer_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
            end
`endif
            HOLD: begin
                buzzer_d = 1'b0;
                if (tick) begin
                    if (cnt_q == CNT_W'(HOLD_S - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                buzzer_d = 1'b0;
            end
        endcase
        feedback_d = (state_d != IDLE);
        ringing_d  = (state_d == RING);
    end

endmodule
